// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: bus widths,
// stall encoding, load codes and the EX->MEM bus layout.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 146;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_ID_WD = 104;
  localparam int STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic [3:0] LOAD_LW  = 4'b1111;
  localparam logic [3:0] LOAD_LB  = 4'b0001;
  localparam logic [3:0] LOAD_LBU = 4'b0010;
  localparam logic [3:0] LOAD_LH  = 4'b0011;
  localparam logic [3:0] LOAD_LHU = 4'b0100;

  // Field order fixes the bit offsets of the EX->MEM bus, MSB first.
  typedef struct packed {
    logic [3:0]  readen;     // [145:142]
    logic        hi_we;      // [141]
    logic [31:0] hi;         // [140:109]
    logic        lo_we;      // [108]
    logic [31:0] lo;         // [107:76]
    logic [31:0] pc;         // [75:44]
    logic        ram_en;     // [43]
    logic [3:0]  ram_wen;    // [42:39]
    logic        sel_rf_res; // [38]
    logic        rf_we;      // [37]
    logic [4:0]  rf_waddr;   // [36:32]
    logic [31:0] ex_result;  // [31:0]
  } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks the byte/halfword addressed by a
// out of the read word and sign- or zero-extends it according to readen.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  a,
  input  logic [3:0]  readen,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    byte_sel = rd[7:0];
    unique case (a)
      2'd0: byte_sel = rd[7:0];
      2'd1: byte_sel = rd[15:8];
      2'd2: byte_sel = rd[23:16];
      2'd3: byte_sel = rd[31:24];
      default: byte_sel = rd[7:0];
    endcase
  end

  assign half_sel = a[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    load_data = 32'h0;
    case (readen)
      LOAD_LW:  load_data = rd;
      LOAD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: load_data = {24'h0, byte_sel};
      LOAD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: load_data = {16'h0, half_sel};
      default:  load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX->MEM bus, holds SRAM read data across
// stalls, and drives the MEM->WB and MEM->ID buses. Optional misaligned-load
// detection is enabled by defining MEM_UNALIGNED_EXC_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
`ifdef MEM_UNALIGNED_EXC_EN
  ,
  output logic                    mem_addr_exc
`endif
);

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
  logic [31:0]             rdata_hold;
  logic                    hold_vld;
  ex_to_mem_t              r;
  logic [31:0]             rd;
  logic [31:0]             load_data;
  logic [31:0]             rf_wdata;
  logic                    rf_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_to_mem_bus_r <= '0;
      rdata_hold      <= 32'h0;
      hold_vld        <= 1'b0;
    end else if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
      ex_to_mem_bus_r <= '0;
      hold_vld        <= 1'b0;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      ex_to_mem_bus_r <= ex_to_mem_bus;
      hold_vld        <= 1'b0;
    end else if (!hold_vld) begin
      // SRAM data is only valid in the first MEM cycle; keep it for the stall.
      rdata_hold <= data_sram_rdata;
      hold_vld   <= 1'b1;
    end
  end

  assign r  = ex_to_mem_bus_r;
  assign rd = hold_vld ? rdata_hold : data_sram_rdata;

  load_align u_load_align (
    .rd        (rd),
    .a         (r.ex_result[1:0]),
    .readen    (r.readen),
    .load_data (load_data)
  );

  assign rf_wdata = r.sel_rf_res ? load_data : r.ex_result;

`ifdef MEM_UNALIGNED_EXC_EN
  logic is_half;
  assign is_half      = (r.readen == LOAD_LH) || (r.readen == LOAD_LHU);
  assign mem_addr_exc = ((r.readen == LOAD_LW) && (r.ex_result[1:0] != 2'b00)) ||
                        (is_half && r.ex_result[0]);
  assign rf_we        = r.rf_we & ~mem_addr_exc;
`else
  assign rf_we        = r.rf_we;
`endif

  assign mem_to_wb_bus = {r.hi_we, r.hi, r.lo_we, r.lo, r.pc,
                          rf_we, r.rf_waddr, rf_wdata};
  assign mem_to_id_bus = {r.hi_we, r.hi, r.lo_we, r.lo,
                          rf_we, r.rf_waddr, rf_wdata};

  // Store-side fields and other stages' stall bits are consumed elsewhere.
  logic unused_ok;
  assign unused_ok = ^{r.ram_en, r.ram_wen, stall[5], stall[2:0]};

endmodule
